// File: rtl/gain_stage_tdm.sv
// gain_stage_tdm: per-channel gain for a time-multiplexed sample stream.
// Three-stage pipeline (capture, multiply, round/shift/saturate), fixed
// 3-cycle latency, one sample per cycle, no backpressure.
// Optional macro GAIN_STAGE_ROUND_EN: round half up before the final shift;
// when undefined the shift truncates toward minus infinity.
module gain_stage_tdm #(
    parameter int IN_W      = 12,
    parameter int OUT_W     = 16,
    parameter int GAIN_W    = 11,
    parameter int GAIN_FRAC = 6,
    parameter int CHANNELS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              ch_first,
    input  logic [IN_W-1:0]   sample_in,
    input  logic              gain_we,
    input  logic [3:0]        gain_ch,
    input  logic [GAIN_W-1:0] gain_value,
    output logic              out_valid,
    output logic [OUT_W-1:0]  sample_out,
    output logic [3:0]        out_ch,
    output logic              clip
);

    localparam int S  = GAIN_FRAC - (OUT_W - IN_W);
    localparam int PW = IN_W + GAIN_W + 1;
    localparam int RW = PW + 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(2 ** GAIN_FRAC);
`ifdef GAIN_STAGE_ROUND_EN
    localparam logic [RW-1:0] HALF = RW'(2 ** (S - 1));
`endif

    // Channel counter and per-channel gains
    logic [3:0]        ch_cnt_q, ch_cnt_d;
    logic [3:0]        cur_ch;
    logic [GAIN_W-1:0] gain_q [CHANNELS];
    logic [GAIN_W-1:0] gain_sel;

    // Stage 1
    logic              s1_valid_q;
    logic [IN_W-1:0]   s1_sample_q;
    logic [3:0]        s1_ch_q;
    logic [GAIN_W-1:0] s1_gain_q;

    // Stage 2
    logic              s2_valid_q;
    logic [3:0]        s2_ch_q;
    logic signed [PW-1:0] p_d, p_q;

    // Stage 3 / outputs
    logic signed [RW-1:0] rnd, sh;
    logic [OUT_W-1:0]  sat;
    logic              ovf;
    logic              out_valid_q;
    logic [OUT_W-1:0]  sample_out_q;
    logic [3:0]        out_ch_q;
    logic              clip_q;

    // Channel of the incoming sample, next count, and its gain lookup
    always_comb begin
        cur_ch = ch_first ? 4'd0 : ch_cnt_q;
        if (!valid) begin
            ch_cnt_d = ch_cnt_q;
        end else if (cur_ch == 4'(CHANNELS - 1)) begin
            ch_cnt_d = '0;
        end else begin
            ch_cnt_d = cur_ch + 4'd1;
        end
        gain_sel = gain_q[0];
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cur_ch == 4'(c)) begin
                gain_sel = gain_q[c];
            end
        end
    end

    // Channel counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_cnt_q <= '0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
        end
    end

    // Gain register file; writes to channels beyond CHANNELS-1 match no entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                gain_q[c] <= UNITY;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (gain_we && gain_ch == 4'(c)) begin
                    gain_q[c] <= gain_value;
                end
            end
        end
    end

    // Signed product; operands pre-extended so the multiply is exact at PW bits
    always_comb begin
        p_d = $signed({{(PW - IN_W){s1_sample_q[IN_W-1]}}, s1_sample_q})
            * $signed({{(PW - GAIN_W){1'b0}}, s1_gain_q});
    end

    // Stage 1 and stage 2 registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sample_q <= '0;
            s1_ch_q     <= '0;
            s1_gain_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            p_q         <= '0;
        end else begin
            s1_valid_q  <= valid;
            s1_sample_q <= sample_in;
            s1_ch_q     <= cur_ch;
            s1_gain_q   <= gain_sel;
            s2_valid_q  <= s1_valid_q;
            s2_ch_q     <= s1_ch_q;
            p_q         <= p_d;
        end
    end

    // Round (optional), arithmetic shift and saturate to OUT_W
    always_comb begin
`ifdef GAIN_STAGE_ROUND_EN
        rnd = $signed({p_q[PW-1], p_q}) + $signed(HALF);
`else
        rnd = $signed({p_q[PW-1], p_q});
`endif
        sh  = rnd >>> S;
        ovf = !((&sh[RW-1:OUT_W-1]) || !(|sh[RW-1:OUT_W-1]));
        if (!ovf) begin
            sat = sh[OUT_W-1:0];
        end else if (sh[RW-1]) begin
            sat = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end

    // Output registers; data fields hold while no result is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            sample_out_q <= '0;
            out_ch_q     <= '0;
            clip_q       <= 1'b0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                sample_out_q <= sat;
                out_ch_q     <= s2_ch_q;
                clip_q       <= ovf;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign sample_out = sample_out_q;
    assign out_ch     = out_ch_q;
    assign clip       = clip_q;

endmodule

// File: doc/gain_stage_tdm.md
GAIN_STAGE_TDM -- requirements
Module: gain_stage_tdm

Interface
REQ-001 Parameter IN_W, default 12: input sample width, signed two's complement.
REQ-002 Parameter OUT_W, default 16: output sample width, signed; OUT_W >= IN_W.
REQ-003 Parameter GAIN_W, default 11: gain width, unsigned fixed point.
REQ-004 Parameter GAIN_FRAC, default 6: gain fractional bits, so gain 64 = 1.0; S = GAIN_FRAC - (OUT_W - IN_W) >= 1, default S = 2.
REQ-005 Parameter CHANNELS, default 2: number of time-multiplexed channels, range 1..16.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 valid  input  1  sample_in is valid this cycle.
REQ-009 ch_first  input  1  qualified by valid; marks the sample as channel 0.
REQ-010 sample_in  input  IN_W  signed input sample.
REQ-011 gain_we  input  1  write strobe for a per-channel gain.
REQ-012 gain_ch  input  4  channel index for the gain write.
REQ-013 gain_value  input  GAIN_W  gain to write.
REQ-014 out_valid  output  1  sample_out, out_ch and clip are valid this cycle.
REQ-015 sample_out  output  OUT_W  signed scaled, saturated sample.
REQ-016 out_ch  output  4  channel index of sample_out.
REQ-017 clip  output  1  sample_out was saturated.

Function
REQ-018 Channel counter: a valid sample with ch_first=1 is channel 0 and sets the counter to 1 (wrapping to 0 when CHANNELS=1).
REQ-019 Channel counter: a valid sample with ch_first=0 uses the current count, then the count increments and wraps from CHANNELS-1 to 0.
REQ-020 The block holds one gain register per channel; gain_we writes gain_value to gain[gain_ch]; a write with gain_ch >= CHANNELS is ignored.
REQ-021 The gain is sampled when the sample is accepted (stage 1); a same-cycle write to the same channel applies from the next sample of that channel.
REQ-022 Pipeline has 3 stages: S1 registers the sample, channel and gain; S2 registers P = sample_in * gain as a signed IN_W+GAIN_W+1-bit product; S3 rounds, shifts and saturates.
REQ-023 Latency is exactly 3 cycles: out_valid is valid delayed by 3 cycles; there is no backpressure and a new sample may be accepted every cycle.
REQ-024 Result is R = P >>> S (arithmetic shift), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 clip=1 exactly when saturation changed the value; clip is qualified by out_valid.
REQ-026 While out_valid=0, sample_out, out_ch and clip hold their last values.
REQ-027 Gain 0 yields 0 and clip=0; the maximum gain times the most negative input saturates to -2^(OUT_W-1).

Reset
REQ-028 Reset asserted asynchronously clears out_valid, sample_out, out_ch, clip, the channel counter and all pipeline valid bits to 0.
REQ-029 Reset sets every gain register to 2^GAIN_FRAC (unity).
REQ-030 Samples in flight when reset asserts are discarded; no out_valid is produced for them after release.
REQ-031 After release, the first valid sample is accepted on the first rising edge.

Configuration
REQ-032 With GAIN_STAGE_ROUND_EN defined, S3 adds 2^(S-1) to P before the shift (round half up).
REQ-033 Without GAIN_STAGE_ROUND_EN, S3 truncates (floor by arithmetic shift); all other behaviour is identical.

Verification
REQ-034 Unity gain: gains at reset, sample 100 on ch0 -> sample_out 1600, out_ch 0, clip 0, out_valid exactly 3 cycles later.
REQ-035 Saturation: gain[1]=2047, sample 2047 on ch1 -> sample_out 32767, clip 1; sample -2048 at unity -> -32768, clip 0.
REQ-036 Rounding: gain 2, sample 1 -> 1 with the macro, 0 without; sample -1 -> 0 with the macro, -1 without.
REQ-037 TDM: CHANNELS=2, back-to-back valid with ch_first on every 2nd sample, gain[0]=64, gain[1]=32, samples 100 -> 1600/800 alternating; a stray ch_first resynchronises to ch0.
REQ-038 Reset mid-stream: assert rst with 3 samples in flight -> outputs 0 immediately, no out_valid after release, gains back to 64.
